// File: rtl/proc_seq_if.sv
// proc_seq_if: host/program port and proc-facing DIN/Run/Done bundle of the proc_seq sequencer.
interface proc_seq_if #(
   parameter int DATAWIDTH = 6,
   parameter int ADDR_W    = 4
);
   logic                 start;
   logic                 stop;
   logic [ADDR_W-1:0]    last_addr;
   logic                 prog_we;
   logic [ADDR_W-1:0]    prog_addr;
   logic [DATAWIDTH-1:0] prog_wdata;
   logic                 Done;
   logic [DATAWIDTH-1:0] DIN;
   logic                 Run;
   logic                 busy;
   logic                 prog_done;
   logic                 fault;
   logic [ADDR_W-1:0]    pc;
   logic [7:0]           instr_cnt;

   modport master (
      output start, stop, last_addr, prog_we, prog_addr, prog_wdata, Done,
      input  DIN, Run, busy, prog_done, fault, pc, instr_cnt
   );

   modport slave (
      input  start, stop, last_addr, prog_we, prog_addr, prog_wdata, Done,
      output DIN, Run, busy, prog_done, fault, pc, instr_cnt
   );
endinterface

// File: rtl/proc_seq.sv
// proc_seq: program memory + IDLE/ISSUE/EXEC sequencer feeding proc DIN/Run with a Done watchdog.
// Define PROC_SEQ_LOOP_EN to restart the program at address 0 instead of returning to IDLE at its end.
module proc_seq #(
   parameter int DATAWIDTH = 6,
   parameter int ADDR_W    = 4,
   parameter int TIMEOUT   = 7
) (
   input  logic      Clock,
   input  logic      Resetn,
   proc_seq_if.slave bus
);
`ifdef PROC_SEQ_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] ONE = 1;

   typedef enum logic [1:0] {IDLE, ISSUE, EXEC} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d, last_q, last_d, op_q, op_d;
   logic                 is_mvi_q, is_mvi_d, run_q, run_d, done_q, done_d, fault_q, fault_d;
   logic [WD_W-1:0]      wdog_q, wdog_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [DATAWIDTH-1:0] mem_q [2**ADDR_W];
   logic [DATAWIDTH-1:0] word;
   logic                 at_end;

   assign word   = mem_q[pc_q];
   // In EXEC pc_q already points one past the opcode, i.e. at the mvi data word.
   assign at_end = (op_q == last_q) || (is_mvi_q && pc_q == last_q);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      last_d   = last_q;
      op_d     = op_q;
      is_mvi_d = is_mvi_q;
      wdog_d   = wdog_q;
      cnt_d    = cnt_q;
      fault_d  = fault_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = ISSUE;
            pc_d    = '0;
            last_d  = bus.last_addr;
            fault_d = 1'b0;
            cnt_d   = '0;
         end
         ISSUE: begin
            is_mvi_d = word[DATAWIDTH-1 -: 2] == 2'b01;
            op_d     = pc_q;
            pc_d     = pc_q + ONE;
            wdog_d   = '0;
            state_d  = EXEC;
         end
         EXEC: if (bus.Done) begin
            cnt_d   = cnt_q + 8'd1;
            pc_d    = (LOOP && at_end) ? '0 : is_mvi_q ? pc_q + ONE : pc_q;
            done_d  = at_end;
            state_d = ((at_end && !LOOP) || bus.stop) ? IDLE : ISSUE;
         end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            fault_d = 1'b1;
            state_d = IDLE;
         end else begin
            wdog_d = wdog_q + WD_W'(1);
         end
         default: state_d = IDLE;
      endcase
      run_d = state_d != IDLE;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         last_q   <= '0;
         op_q     <= '0;
         is_mvi_q <= 1'b0;
         wdog_q   <= '0;
         cnt_q    <= '0;
         fault_q  <= 1'b0;
         done_q   <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         last_q   <= last_d;
         op_q     <= op_d;
         is_mvi_q <= is_mvi_d;
         wdog_q   <= wdog_d;
         cnt_q    <= cnt_d;
         fault_q  <= fault_d;
         done_q   <= done_d;
         run_q    <= run_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (bus.prog_we && state_q == IDLE) mem_q[bus.prog_addr] <= bus.prog_wdata;
   end

   assign bus.DIN       = run_q ? word : '0;
   assign bus.Run       = run_q;
   assign bus.busy      = run_q;
   assign bus.prog_done = done_q;
   assign bus.fault     = fault_q;
   assign bus.pc        = pc_q;
   assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_proc_seq.sv
// tb_proc_seq: drives proc_seq against a small proc datapath model and an instruction-level reference.
module tb_proc_seq;
   localparam int DW = 6;
   localparam int AW = 4;
   localparam int TO = 7;
`ifdef PROC_SEQ_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic kill = 1'b0;
   logic pclr = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [5:0]      mm [16];
   logic [1:0]      ts;
   logic [5:0]      ir, acc, g;
   logic [3:0][5:0] preg;
   logic            p_done;

   always #5 clk = ~clk;

   proc_seq_if #(.DATAWIDTH(DW), .ADDR_W(AW)) bus ();
   proc_seq #(.DATAWIDTH(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (.Clock(clk), .Resetn(rstn), .bus(bus));

   // proc datapath: T0 loads IR, mv/mvi finish at T1, add/sub at T3
   assign p_done   = (ts == 2'd1 && !ir[5]) || ts == 2'd3;
   assign bus.Done = p_done & ~kill;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ts <= 2'd0; ir <= '0; acc <= '0; g <= '0; preg <= '0;
      end else if (pclr) begin
         ts <= 2'd0;
      end else begin
         case (ts)
            2'd0: if (bus.Run) begin ir <= bus.DIN; ts <= 2'd1; end
            2'd1: begin
               if (ir[5:4] == 2'b00) begin preg[ir[3:2]] <= preg[ir[1:0]]; ts <= 2'd0; end
               else if (ir[5:4] == 2'b01) begin preg[ir[3:2]] <= bus.DIN; ts <= 2'd0; end
               else begin acc <= preg[ir[3:2]]; ts <= 2'd2; end
            end
            2'd2: begin g <= ir[4] ? acc - preg[ir[1:0]] : acc + preg[ir[1:0]]; ts <= 2'd3; end
            default: begin preg[ir[3:2]] <= g; ts <= 2'd0; end
         endcase
      end
   end

   // Reference: walks the program instruction by instruction from address 0
   task automatic model(input logic [3:0] last, input logic [3:0][5:0] rin, output logic [3:0][5:0] rout,
                        output int cnt, output int cyc, output logic [3:0] pcf, output int last_iss);
      logic [3:0] pc, oa;
      logic [5:0] op;
      bit fin;
      rout = rin; pc = 4'd0; cnt = 0; cyc = 0; fin = 1'b0; last_iss = 0;
      while (!fin && cnt < 64) begin
         op = mm[pc]; oa = pc; pc = pc + 4'd1; last_iss = cyc + 1; fin = (oa == last);
         case (op[5:4])
            2'b00: begin rout[op[3:2]] = rout[op[1:0]]; cyc += 2; end
            2'b01: begin rout[op[3:2]] = mm[pc]; fin = fin || (pc == last); pc = pc + 4'd1; cyc += 2; end
            2'b10: begin rout[op[3:2]] = rout[op[3:2]] + rout[op[1:0]]; cyc += 4; end
            default: begin rout[op[3:2]] = rout[op[3:2]] - rout[op[1:0]]; cyc += 4; end
         endcase
         cnt++;
      end
      pcf = pc;
   endtask

   task automatic load(input int n);
      for (int a = 0; a < n; a++) begin
         bus.prog_we = 1'b1; bus.prog_addr = a[3:0]; bus.prog_wdata = mm[a];
         @(posedge clk); #1;
      end
      bus.prog_we = 1'b0;
   endtask

   task automatic set_fixed();
      mm[0] = 6'b010000; mm[1] = 6'b000101; mm[2] = 6'b010100;
      mm[3] = 6'b000011; mm[4] = 6'b100001; mm[5] = 6'b110001;
   endtask

   // Starts a run (cycle 0 = start cycle) and observes it until busy drops or the budget runs out
   task automatic go(input logic [3:0] last, input int stop_at, input int we_at, input logic [3:0] we_addr,
                     input logic [5:0] we_data, input int start_at, output int pd_cyc, output int n_pd,
                     output int end_cyc, output logic [5:0] din1, output logic flt1);
      int cyc;
      bus.last_addr = last; bus.start = 1'b1;
      bus.prog_we = (we_at == 0); bus.prog_addr = we_addr; bus.prog_wdata = we_data;
      @(posedge clk); #1;
      cyc = 1; pd_cyc = -1; n_pd = 0; din1 = bus.DIN; flt1 = bus.fault;
      while (cyc < 400) begin
         bus.start = (cyc == start_at);
         bus.prog_we = (cyc == we_at);
         if (cyc == stop_at) bus.stop = 1'b1;
         if (bus.prog_done) begin n_pd++; if (pd_cyc < 0) pd_cyc = cyc; end
         if (!bus.busy) break;
         @(posedge clk); #1;
         cyc++;
      end
      bus.start = 1'b0; bus.prog_we = 1'b0; bus.stop = 1'b0;
      end_cyc = bus.busy ? -1 : cyc;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.Run, bus.DIN, bus.busy, bus.prog_done, bus.fault, bus.pc, bus.instr_cnt} !== '0) begin
         errors++; $display("FAIL reset_held: got %h exp 0", {bus.Run, bus.DIN, bus.busy, bus.prog_done, bus.fault, bus.pc, bus.instr_cnt});
      end
      rstn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.Run, bus.busy, bus.fault, bus.pc, bus.instr_cnt} !== '0) begin
         errors++; $display("FAIL reset_idle: got %h exp 0", {bus.Run, bus.busy, bus.fault, bus.pc, bus.instr_cnt});
      end
   endtask

   task automatic test_single_pass();
      int pd, np, ec, cnt, cyc, li;
      logic [5:0] d1;
      logic f1;
      logic [3:0] pcf;
      logic [3:0][5:0] rexp;
      set_fixed(); load(6);
      model(4'd5, preg, rexp, cnt, cyc, pcf, li);
      go(4'd5, LOOP ? li : -1, -1, 4'd0, 6'd0, -1, pd, np, ec, d1, f1);
      checks++; if (pd !== cyc + 1) begin errors++; $display("FAIL single_pd_cycle: got %0d exp %0d", pd, cyc + 1); end
      checks++; if (np !== 1) begin errors++; $display("FAIL single_pd_count: got %0d exp 1", np); end
      checks++; if (ec !== cyc + 1) begin errors++; $display("FAIL single_idle_cycle: got %0d exp %0d", ec, cyc + 1); end
      checks++; if (bus.instr_cnt !== 8'(cnt)) begin errors++; $display("FAIL single_cnt: got %0d exp %0d", bus.instr_cnt, cnt); end
      checks++; if (preg !== rexp) begin errors++; $display("FAIL single_regs: got %h exp %h", preg, rexp); end
      checks++; if (preg[0] !== 6'd5) begin errors++; $display("FAIL single_r0: got %0d exp 5", preg[0]); end
      checks++; if (bus.Run !== 1'b0) begin errors++; $display("FAIL single_run_after: got %b exp 0", bus.Run); end
      checks++; if (bus.pc !== (LOOP ? 4'd0 : pcf)) begin errors++; $display("FAIL single_pc: got %0d exp %0d", bus.pc, LOOP ? 4'd0 : pcf); end
      checks++; if (d1 !== mm[0]) begin errors++; $display("FAIL single_issue_din: got %h exp %h", d1, mm[0]); end
   endtask

   task automatic test_start_write();
      int pd, np, ec, cnt, cyc, li;
      logic [5:0] d1;
      logic f1;
      logic [3:0] pcf;
      logic [3:0][5:0] rexp;
      set_fixed(); load(6);
      mm[0] = 6'b011000;
      model(4'd5, preg, rexp, cnt, cyc, pcf, li);
      go(4'd5, LOOP ? li : -1, 0, 4'd0, 6'b011000, -1, pd, np, ec, d1, f1);
      checks++; if (d1 !== 6'b011000) begin errors++; $display("FAIL startwr_din: got %h exp 18", d1); end
      checks++; if (preg !== rexp) begin errors++; $display("FAIL startwr_regs: got %h exp %h", preg, rexp); end
      checks++; if (pd !== cyc + 1) begin errors++; $display("FAIL startwr_pd_cycle: got %0d exp %0d", pd, cyc + 1); end
   endtask

   task automatic test_write_protect();
      int pd, np, ec, cnt, cyc, li;
      logic [5:0] d1;
      logic f1;
      logic [3:0] pcf;
      logic [3:0][5:0] rexp;
      set_fixed(); load(6);
      model(4'd5, preg, rexp, cnt, cyc, pcf, li);
      go(4'd5, LOOP ? li : -1, 2, 4'd2, ~mm[2], 6, pd, np, ec, d1, f1);
      checks++; if (preg !== rexp) begin errors++; $display("FAIL wp_run1_regs: got %h exp %h", preg, rexp); end
      checks++; if (bus.instr_cnt !== 8'(cnt)) begin errors++; $display("FAIL wp_run1_cnt: got %0d exp %0d", bus.instr_cnt, cnt); end
      checks++; if (pd !== cyc + 1) begin errors++; $display("FAIL wp_run1_pd_cycle: got %0d exp %0d", pd, cyc + 1); end
      model(4'd5, preg, rexp, cnt, cyc, pcf, li);
      go(4'd5, LOOP ? li : -1, -1, 4'd0, 6'd0, -1, pd, np, ec, d1, f1);
      checks++; if (preg !== rexp) begin errors++; $display("FAIL wp_run2_regs: got %h exp %h", preg, rexp); end
      checks++; if (pd !== cyc + 1) begin errors++; $display("FAIL wp_run2_pd_cycle: got %0d exp %0d", pd, cyc + 1); end
   endtask

   task automatic test_stop();
      int pd, np, ec, cnt, cyc, li;
      logic [5:0] d1;
      logic f1;
      logic [3:0] pcf;
      logic [3:0][5:0] rexp;
      set_fixed(); load(6);
      model(4'd4, preg, rexp, cnt, cyc, pcf, li);
      go(4'd5, 6, -1, 4'd0, 6'd0, -1, pd, np, ec, d1, f1);
      checks++; if (bus.instr_cnt !== 8'd3) begin errors++; $display("FAIL stop_cnt: got %0d exp 3", bus.instr_cnt); end
      checks++; if (np !== 0) begin errors++; $display("FAIL stop_no_pd: got %0d exp 0", np); end
      checks++; if (ec !== cyc + 1) begin errors++; $display("FAIL stop_idle_cycle: got %0d exp %0d", ec, cyc + 1); end
      checks++; if (preg !== rexp) begin errors++; $display("FAIL stop_regs: got %h exp %h", preg, rexp); end
   endtask

   task automatic test_watchdog();
      int pd, np, ec, cnt, cyc, li;
      logic [5:0] d1;
      logic f1;
      logic [3:0] pcf;
      logic [3:0][5:0] rexp;
      set_fixed(); load(6);
      kill = 1'b1;
      go(4'd5, -1, -1, 4'd0, 6'd0, -1, pd, np, ec, d1, f1);
      checks++; if (ec !== TO + 2) begin errors++; $display("FAIL wd_fault_cycle: got %0d exp %0d", ec, TO + 2); end
      checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL wd_fault: got %b exp 1", bus.fault); end
      checks++; if (bus.Run !== 1'b0) begin errors++; $display("FAIL wd_run: got %b exp 0", bus.Run); end
      checks++; if (np !== 0 || bus.instr_cnt !== 8'd0) begin errors++; $display("FAIL wd_no_progress: got pd %0d cnt %0d exp 0 0", np, bus.instr_cnt); end
      kill = 1'b0; pclr = 1'b1;
      @(posedge clk); #1;
      pclr = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b exp 1", bus.fault); end
      model(4'd5, preg, rexp, cnt, cyc, pcf, li);
      go(4'd5, LOOP ? li : -1, -1, 4'd0, 6'd0, -1, pd, np, ec, d1, f1);
      checks++; if (f1 !== 1'b0) begin errors++; $display("FAIL wd_cleared_by_start: got %b exp 0", f1); end
      checks++; if (preg !== rexp || pd !== cyc + 1) begin errors++; $display("FAIL wd_rerun: got %h/%0d exp %h/%0d", preg, pd, rexp, cyc + 1); end
   endtask

   task automatic test_wrap();
      int pd, np, ec, cnt, cyc, li;
      logic [5:0] d1;
      logic f1;
      logic [3:0] pcf;
      logic [3:0][5:0] rexp;
      mm[0] = 6'h2A;
      for (int a = 1; a < 15; a++) mm[a] = 6'b000000;
      mm[15] = 6'b011100;
      load(16);
      model(4'd15, preg, rexp, cnt, cyc, pcf, li);
      go(4'd15, LOOP ? li : -1, -1, 4'd0, 6'd0, -1, pd, np, ec, d1, f1);
      checks++; if (preg[3] !== 6'h2A) begin errors++; $display("FAIL wrap_r3: got %h exp 2a", preg[3]); end
      checks++; if (preg !== rexp) begin errors++; $display("FAIL wrap_regs: got %h exp %h", preg, rexp); end
      checks++; if (pd !== cyc + 1 || np !== 1) begin errors++; $display("FAIL wrap_pd: got %0d x%0d exp %0d x1", pd, np, cyc + 1); end
      checks++; if (bus.instr_cnt !== 8'(cnt)) begin errors++; $display("FAIL wrap_cnt: got %0d exp %0d", bus.instr_cnt, cnt); end
      checks++; if (bus.pc !== (LOOP ? 4'd0 : pcf)) begin errors++; $display("FAIL wrap_pc: got %0d exp %0d", bus.pc, LOOP ? 4'd0 : pcf); end
   endtask

   task automatic test_random();
      int pd, np, ec, cnt, cyc, li, a, n;
      logic [5:0] d1;
      logic f1;
      logic [3:0] pcf, last;
      logic [1:0] op;
      logic [3:0][5:0] rexp;
      for (int it = 0; it < 4; it++) begin
         a = 0;
         n = $urandom_range(3, 6);
         for (int i = 0; i < n; i++) begin
            op = 2'($urandom_range(0, 3));
            mm[a] = {op, 4'($urandom)};
            a++;
            if (op == 2'b01) begin mm[a] = 6'($urandom); a++; end
         end
         last = 4'(a - 1);
         load(a);
         model(last, preg, rexp, cnt, cyc, pcf, li);
         go(last, LOOP ? li : -1, -1, 4'd0, 6'd0, -1, pd, np, ec, d1, f1);
         checks++; if (preg !== rexp) begin errors++; $display("FAIL rand%0d_regs: got %h exp %h", it, preg, rexp); end
         checks++; if (bus.instr_cnt !== 8'(cnt)) begin errors++; $display("FAIL rand%0d_cnt: got %0d exp %0d", it, bus.instr_cnt, cnt); end
         checks++; if (pd !== cyc + 1 || np !== 1) begin errors++; $display("FAIL rand%0d_pd: got %0d x%0d exp %0d x1", it, pd, np, cyc + 1); end
         checks++; if (bus.pc !== (LOOP ? 4'd0 : pcf)) begin errors++; $display("FAIL rand%0d_pc: got %0d exp %0d", it, bus.pc, LOOP ? 4'd0 : pcf); end
      end
   endtask

`ifdef PROC_SEQ_LOOP_EN
   task automatic test_loop();
      int pd, np, ec, cnt, cyc, li;
      logic [5:0] d1;
      logic f1;
      logic [3:0] pcf;
      logic [3:0][5:0] rexp;
      set_fixed(); load(6);
      model(4'd5, preg, rexp, cnt, cyc, pcf, li);
      go(4'd5, 2 * cyc + li, -1, 4'd0, 6'd0, -1, pd, np, ec, d1, f1);
      checks++; if (np !== 3) begin errors++; $display("FAIL loop_pd_count: got %0d exp 3", np); end
      checks++; if (pd !== cyc + 1) begin errors++; $display("FAIL loop_first_pd: got %0d exp %0d", pd, cyc + 1); end
      checks++; if (ec !== 3 * cyc + 1) begin errors++; $display("FAIL loop_idle_cycle: got %0d exp %0d", ec, 3 * cyc + 1); end
      checks++; if (bus.instr_cnt !== 8'(3 * cnt)) begin errors++; $display("FAIL loop_cnt: got %0d exp %0d", bus.instr_cnt, 3 * cnt); end
   endtask
`endif

   task automatic test_reset_mid();
      set_fixed(); load(6);
      bus.last_addr = 4'd5; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      checks++; if (bus.busy !== 1'b1 || bus.instr_cnt !== 8'd2) begin errors++; $display("FAIL rstmid_pre: got busy %b cnt %0d exp 1 2", bus.busy, bus.instr_cnt); end
      rstn = 1'b0;
      #1;
      checks++;
      if ({bus.Run, bus.DIN, bus.busy, bus.prog_done, bus.fault, bus.pc, bus.instr_cnt} !== '0) begin
         errors++; $display("FAIL rstmid_outputs: got %h exp 0", {bus.Run, bus.DIN, bus.busy, bus.prog_done, bus.fault, bus.pc, bus.instr_cnt});
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b exp 0", bus.busy); end
   endtask

   initial begin
      bus.start = 1'b0; bus.stop = 1'b0; bus.last_addr = '0;
      bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0;
      test_reset();
      test_single_pass();
      test_start_write();
      test_write_protect();
      test_stop();
      test_watchdog();
      test_wrap();
      test_random();
`ifdef PROC_SEQ_LOOP_EN
      test_loop();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
